alu_multicycle_m: RTL and testbench
===================================

Name: alu_multicycle_m

Overview:
- Next-generation ALU for the multicycle RV32 core.
- Parametrised in datapath width (XLEN).
- Executes the RV32I register/immediate ALU ops in one cycle, and the RV32M multiply/divide ops iteratively, one bit per cycle.
- Sits in the execute stage. The controller issues ops with a start/busy/done handshake and holds its FSM until done.
- ALUResult and Zero are registered.

Parameters:
- XLEN, 32, datapath width in bits (≥8, power of two).
- SHW, $clog2(XLEN), number of shift-amount bits taken from srcB.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  issue request; sampled only when busy=0.
- srcA  input  XLEN  operand A; captured at the start edge.
- srcB  input  XLEN  operand B; captured at the start edge.
- ALUControl  input  10  {funct7[6:0], funct3[2:0]}; captured at the start edge.
- busy  output  1  iterative op in progress.
- done  output  1  one-cycle pulse; ALUResult/Zero updated.
- Zero  output  1  registered (ALUResult == 0), valid for every op.
- ALUResult  output  XLEN  registered result; held until next completion.

Behaviour:
- Reset (async, any state): FSM→IDLE; busy=0, done=0, ALUResult=0, Zero=1; iteration counter and work registers cleared. An op in flight is abandoned with no done.
- States: IDLE, ITER, FIX.
- Encoding, funct7=0000000:
  - 000 ADD; 001 SLL; 010 SLT (signed); 011 SLTU; 100 XOR; 101 SRL; 110 OR; 111 AND.
- Encoding, funct7=0100000: 000 SUB; 101 SRA (arithmetic).
- Encoding, funct7=0000001: 000 MUL; 001 MULH; 010 MULHSU; 011 MULHU; 100 DIV; 101 DIVU; 110 REM; 111 REMU.
- Shifts use srcB[SHW-1:0] only.
- Any other ALUControl completes as a single-cycle op: ALUResult=0, Zero=1.
- Single-cycle ops:
  - start high in cycle c → result registered at end of c → done=1 in cycle c+1.
  - busy stays 0; FSM stays IDLE.
- Divide special cases also complete as single-cycle ops:
  - Divisor=0: DIV/DIVU give all-ones; REM/REMU give srcA.
  - DIV with srcA=100…0 and srcB=all-ones: result 100…0; REM gives 0.
- Iterative ops (MUL*, and DIV*/REM* not covered above):
  - End of cycle c: capture operand magnitudes and sign flags (signedness per op); busy=1; counter=XLEN; →ITER.
  - ITER, cycles c+1..c+XLEN:
    - Multiply: one shift-add step into a 2·XLEN accumulator per cycle.
    - Divide: one restoring step (shift remainder, trial subtract, set quotient bit) per cycle.
    - Counter decrements each cycle; at 1 → FIX.
  - FIX, cycle c+XLEN+1: apply two's-complement sign correction.
    - Product negated if the operand signs differ (signed operands only).
    - Quotient negated if the signs differ; remainder takes the dividend's sign.
    - Select low half (MUL), high half (MULH*), quotient, or remainder.
    - Register ALUResult and Zero; busy=0; →IDLE.
  - done=1 in cycle c+XLEN+2; busy is high for exactly XLEN+1 cycles.
- done is high for exactly one cycle per accepted op and never while busy=1.
- start while busy=1 is ignored: not queued, no effect on the op in flight.
- srcA/srcB/ALUControl changes while busy do not affect the op in flight.
- start asserted in the same cycle that done=1 (busy=0) is accepted normally: back-to-back issue.
- Arithmetic:
  - All results wrap modulo 2^XLEN.
  - SLT/MULH/DIV/REM interpret operands as two's complement.
  - MULHSU: srcA signed, srcB unsigned.
- The block has no simulation-only prints.

Test Plan:
- ADD srcA=5, srcB=7 → done next cycle, ALUResult=12, Zero=0. Then SUB 5,5 → ALUResult=0, Zero=1, busy never high.
- srcA=0xFFFFFFFF, srcB=1: SLT → 1; SLTU → 0. SRA srcA=0x80000000, srcB=0x24 (shamt 4) → 0xF8000000; SRL same operands → 0x08000000.
- srcA=0xFFFFFFFF, srcB=2:
  - MUL → 0xFFFFFFFE; MULH → 0xFFFFFFFF; MULHU → 0x00000001; MULHSU → 0xFFFFFFFF.
  - Each: busy high for 33 cycles, done exactly 34 cycles after the start cycle.
- DIV -7/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 7/0 → 0xFFFFFFFF in 1 cycle; REM 7/0 → 7; DIV 0x80000000/0xFFFFFFFF → 0x80000000 in 1 cycle; REM same operands → 0, Zero=1.
- Start DIVU 100/3, then pulse start with ADD at cycle 5 → ADD ignored, single done with ALUResult=33. ADD issued in the done cycle → completes next cycle.
- Assert reset asynchronously mid-cycle during ITER cycle 10 of MUL → busy=0, ALUResult=0, Zero=1 immediately, no done. After release, MULHU 0x10000,0x10000 → 1.

Source files
------------

// File: rtl/alu_multicycle_m.sv
// rtl/alu_multicycle_m.sv - RV32I/M execute-stage ALU with iterative multiply/divide
module alu_multicycle_m #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    input  logic [9:0]      ALUControl,
    output logic            busy,
    output logic            done,
    output logic            Zero,
    output logic [XLEN-1:0] ALUResult
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d;      // product high half / partial remainder
    logic [XLEN-1:0]   lo_q, lo_d;      // multiplier / dividend shifting into quotient
    logic [XLEN-1:0]   b_q, b_d;        // multiplicand or divisor magnitude
    logic              neg_q, neg_d;    // final result needs negation
    logic              is_mul_q, is_mul_d;
    logic [2:0]        f3_q, f3_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              zero_q, zero_d;
    logic              done_q, done_d;

    logic [6:0]        f7;
    logic [2:0]        f3;
    logic              a_signed, b_signed, neg_a, neg_b;
    logic              div_zero, div_ovf, iter_go;
    logic [XLEN-1:0]   mag_a, mag_b, fast_res, fix_res;
    logic [XLEN:0]     mul_sum, mul_t, div_sh;
    logic [XLEN+1:0]   div_diff;
    logic [2*XLEN-1:0] prod, prod_c;
    logic [XLEN-1:0]   dv;

    assign f7 = ALUControl[9:3];
    assign f3 = ALUControl[2:0];

    // Operand decode: signedness, special divide cases and magnitudes for the iterative path
    always_comb begin
        a_signed = (f7 == 7'b0000001) &&
                   (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b100 || f3 == 3'b110);
        b_signed = (f7 == 7'b0000001) &&
                   (f3 == 3'b001 || f3 == 3'b100 || f3 == 3'b110);
        neg_a    = a_signed && srcA[XLEN-1];
        neg_b    = b_signed && srcB[XLEN-1];
        mag_a    = neg_a ? (~srcA + 1'b1) : srcA;
        mag_b    = neg_b ? (~srcB + 1'b1) : srcB;
        div_zero = (f7 == 7'b0000001) && f3[2] && (srcB == '0);
        div_ovf  = (f7 == 7'b0000001) && (f3 == 3'b100 || f3 == 3'b110) &&
                   (srcA == MIN_NEG) && (srcB == ALL_ONES);
        iter_go  = (f7 == 7'b0000001) && !div_zero && !div_ovf;
    end

    // Single-cycle results, including the divide special cases; unknown encodings give 0
    always_comb begin
        fast_res = '0;
        if (f7 == 7'b0000000) begin
            case (f3)
                3'b000:  fast_res = srcA + srcB;
                3'b001:  fast_res = srcA << srcB[SHW-1:0];
                3'b010:  fast_res = {{(XLEN-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
                3'b011:  fast_res = {{(XLEN-1){1'b0}}, (srcA < srcB)};
                3'b100:  fast_res = srcA ^ srcB;
                3'b101:  fast_res = srcA >> srcB[SHW-1:0];
                3'b110:  fast_res = srcA | srcB;
                default: fast_res = srcA & srcB;
            endcase
        end else if (f7 == 7'b0100000) begin
            if (f3 == 3'b000)
                fast_res = srcA - srcB;
            else if (f3 == 3'b101)
                fast_res = $unsigned($signed(srcA) >>> srcB[SHW-1:0]);
        end else if (div_zero) begin
            fast_res = f3[1] ? srcA : ALL_ONES;
        end else if (div_ovf) begin
            fast_res = f3[1] ? '0 : MIN_NEG;
        end
    end

    // One shift-add and one restoring-divide step, plus the sign-corrected final selection
    always_comb begin
        mul_sum  = {1'b0, hi_q} + {1'b0, b_q};
        mul_t    = lo_q[0] ? mul_sum : {1'b0, hi_q};
        div_sh   = {hi_q, lo_q[XLEN-1]};
        div_diff = {1'b0, div_sh} - {2'b00, b_q};
        prod     = {hi_q, lo_q};
        prod_c   = neg_q ? (~prod + 1'b1) : prod;
        dv       = f3_q[1] ? hi_q : lo_q;
        if (is_mul_q)
            fix_res = (f3_q == 3'b000) ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN];
        else
            fix_res = neg_q ? (~dv + 1'b1) : dv;
    end

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        neg_d    = neg_q;
        is_mul_d = is_mul_q;
        f3_d     = f3_q;
        res_d    = res_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (iter_go) begin
                        state_d  = ITER;
                        cnt_d    = CW'(XLEN);
                        hi_d     = '0;
                        lo_d     = mag_a;
                        b_d      = mag_b;
                        is_mul_d = !f3[2];
                        f3_d     = f3;
                        // Remainder follows the dividend; product and quotient follow sign mismatch
                        neg_d    = (f3[2] && f3[1]) ? neg_a : (neg_a ^ neg_b);
                    end else begin
                        res_d  = fast_res;
                        zero_d = (fast_res == '0);
                        done_d = 1'b1;
                    end
                end
            end
            ITER: begin
                if (is_mul_q) begin
                    hi_d = mul_t[XLEN:1];
                    lo_d = {mul_t[0], lo_q[XLEN-1:1]};
                end else if (!div_diff[XLEN+1]) begin
                    hi_d = div_diff[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b1};
                end else begin
                    hi_d = div_sh[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1))
                    state_d = FIX;
            end
            FIX: begin
                res_d   = fix_res;
                zero_d  = (fix_res == '0);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any op in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            is_mul_q <= 1'b0;
            f3_q     <= 3'b000;
            res_q    <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            is_mul_q <= is_mul_d;
            f3_q     <= f3_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign Zero      = zero_q;
    assign ALUResult = res_q;

endmodule

// File: tb/tb_alu_multicycle_m.sv
// tb/tb_alu_multicycle_m.sv - randomized self-checking bench for alu_multicycle_m
module tb_alu_multicycle_m;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] srcA = '0;
    logic [31:0] srcB = '0;
    logic [9:0]  ALUControl = '0;
    logic        busy, done, Zero;
    logic [31:0] ALUResult;

    alu_multicycle_m #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .srcA(srcA), .srcB(srcB),
        .ALUControl(ALUControl), .busy(busy), .done(done), .Zero(Zero),
        .ALUResult(ALUResult)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int fails = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    // Model timeline: busy window [bs, be], completion cycle and the values it reports
    int          bs = 1, be = 0, done_cyc = -1;
    logic [31:0] pend_res = '0, model_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [9:0] ctl, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [6:0]        f7;
        logic [2:0]        f3;
        logic signed [63:0] sa, sb, sub;
        logic [63:0]       ua, ub, p;
        logic              ovf;
        f7  = ctl[9:3];
        f3  = ctl[2:0];
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        sub = ub;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        model = '0;
        if (f7 == 7'h00) begin
            case (f3)
                3'd0: model = a + b;
                3'd1: model = a << b[4:0];
                3'd2: model = (sa < sb) ? 32'd1 : 32'd0;
                3'd3: model = (a < b) ? 32'd1 : 32'd0;
                3'd4: model = a ^ b;
                3'd5: model = a >> b[4:0];
                3'd6: model = a | b;
                default: model = a & b;
            endcase
        end else if (f7 == 7'h20) begin
            if (f3 == 3'd0) model = a - b;
            else if (f3 == 3'd5) model = 32'(sa >>> b[4:0]);
        end else if (f7 == 7'h01) begin
            case (f3)
                3'd0: begin p = sa * sb;  model = p[31:0];  end
                3'd1: begin p = sa * sb;  model = p[63:32]; end
                3'd2: begin p = sa * sub; model = p[63:32]; end
                3'd3: begin p = ua * ub;  model = p[63:32]; end
                3'd4: model = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
                3'd5: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
                3'd6: model = (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
                default: model = (b == 0) ? a : a % b;
            endcase
        end
    endfunction

    function automatic bit is_iter(input logic [9:0] ctl, input logic [31:0] a,
                                   input logic [31:0] b);
        logic [2:0] f3;
        f3 = ctl[2:0];
        if (ctl[9:3] != 7'h01) return 1'b0;
        if (f3[2] && b == 0) return 1'b0;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b0;
        return 1'b1;
    endfunction

    // Per-cycle comparison of every output against the model timeline
    always @(negedge clk) begin
        if (mon_en) begin
            if (cyc == done_cyc) model_res = pend_res;
            chk("busy", {31'd0, busy}, {31'd0, (cyc >= bs && cyc <= be)});
            chk("done", {31'd0, done}, {31'd0, (cyc == done_cyc)});
            chk("result", ALUResult, model_res);
            chk("zero", {31'd0, Zero}, {31'd0, (model_res == 0)});
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Drive one start pulse in the current cycle; the model decides whether it is accepted
    task automatic issue(input logic [9:0] ctl, input logic [31:0] a, input logic [31:0] b);
        srcA = a;
        srcB = b;
        ALUControl = ctl;
        start = 1'b1;
        if (!(cyc >= bs && cyc <= be)) begin
            pend_res = model(ctl, a, b);
            if (is_iter(ctl, a, b)) begin
                bs = cyc + 1;
                be = cyc + 33;
                done_cyc = cyc + 34;
            end else begin
                done_cyc = cyc + 1;
            end
        end
        step();
        start = 1'b0;
        srcA = $urandom;
        srcB = $urandom;
        ALUControl = 10'($urandom);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((cyc < done_cyc || cyc <= be) && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) chk("wait_timeout", 32'd1, 32'd0);
    endtask

    task automatic run(input string nm, input logic [9:0] ctl, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] lit);
        chk({nm, "_model"}, model(ctl, a, b), lit);
        issue(ctl, a, b);
        wait_done();
        chk(nm, ALUResult, lit);
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom % 7)
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom % 16);
            default: return $urandom;
        endcase
    endfunction

    localparam logic [9:0] ADD = 10'h000, SUB = 10'h100, SLT = 10'h002, SLTU = 10'h003;
    localparam logic [9:0] SRL = 10'h005, SRA = 10'h105;
    localparam logic [9:0] MUL = 10'h008, MULH = 10'h009, MULHSU = 10'h00A, MULHU = 10'h00B;
    localparam logic [9:0] DIV = 10'h00C, DIVU = 10'h00D, REM = 10'h00E;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [9:0] ops [20];
        ops = '{10'h000, 10'h001, 10'h002, 10'h003, 10'h004, 10'h005, 10'h006, 10'h007,
                10'h100, 10'h105, 10'h008, 10'h009, 10'h00A, 10'h00B, 10'h00C, 10'h00D,
                10'h00E, 10'h00F, 10'h101, 10'h3C5};
        step();
        step();
        mon_en = 1'b1;
        chk("reset_result", ALUResult, 32'd0);
        chk("reset_zero", {31'd0, Zero}, 32'd1);
        reset = 1'b0;
        step();

        run("add", ADD, 32'd5, 32'd7, 32'd12);
        run("sub", SUB, 32'd5, 32'd5, 32'd0);
        chk("sub_zero", {31'd0, Zero}, 32'd1);
        run("slt", SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
        run("sltu", SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
        run("sra", SRA, 32'h8000_0000, 32'h24, 32'hF800_0000);
        run("srl", SRL, 32'h8000_0000, 32'h24, 32'h0800_0000);
        run("mul", MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
        run("mulh", MULH, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        run("mulhu", MULHU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001);
        run("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        run("div", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run("rem", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run("divu_by0", DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF);
        run("rem_by0", REM, 32'd7, 32'd0, 32'd7);
        run("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        chk("rem_ovf_zero", {31'd0, Zero}, 32'd1);

        // Start ignored while busy, then back-to-back issue in the done cycle
        issue(DIVU, 32'd100, 32'd3);
        repeat (3) step();
        issue(ADD, 32'd1, 32'd2);
        wait_done();
        chk("divu_ignore", ALUResult, 32'd33);
        run("add_b2b", ADD, 32'd40, 32'd2, 32'd42);

        // Asynchronous reset in the middle of an iterative op
        issue(MUL, 32'hFFFF_FFFF, 32'd2);
        repeat (9) step();
        #2;
        reset = 1'b1;
        bs = 1;
        be = 0;
        done_cyc = -1;
        model_res = '0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_result", ALUResult, 32'd0);
        chk("arst_zero", {31'd0, Zero}, 32'd1);
        step();
        step();
        reset = 1'b0;
        step();
        run("mulhu_post", MULHU, 32'h0001_0000, 32'h0001_0000, 32'd1);

        // Randomized traffic with random gaps, some issued while still busy
        for (int k = 0; k < 150; k++) begin
            logic [9:0] c;
            c = ($urandom % 8 == 0) ? 10'($urandom) : ops[$urandom % 20];
            issue(c, rand_opnd(), rand_opnd());
            if ($urandom % 4 != 0) wait_done();
            repeat ($urandom % 3) step();
        end
        wait_done();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
